// File: rtl/woz_pkg.sv
// woz_pkg: shared WOZ track-slot layout constants, writer FSM states and the slot LBA helper
package woz_pkg;
  localparam int WOZ_META_BYTES = 8;
  localparam int WOZ_BLK_BYTES = 512;
  localparam int WOZ_BLK_SHIFT = 5;
  typedef enum logic [1:0] {IDLE, REQ, XFER, NEXT} wtw_state_t;
  function automatic logic [31:0] woz_lba(input logic side, input logic [6:0] track);
    return 32'({side, track}) << WOZ_BLK_SHIFT;
  endfunction
endpackage

// File: rtl/woz_wb_ram.sv
// woz_wb_ram: 16384x8 simple dual-port track buffer with a registered read port
module woz_wb_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [13:0] waddr,
  input  logic [7:0]  wdata,
  input  logic [13:0] raddr,
  output logic [7:0]  rdata_q
);
  logic [7:0] mem [16384];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
endmodule

// File: rtl/woz_track_writer.sv
// woz_track_writer: captures drive track writes into BRAM and flushes them to the SD image block by block
module woz_track_writer
  import woz_pkg::*;
#(
  parameter int MAX_BLOCKS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [13:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic [6:0]  track,
  input  logic        side,
  input  logic [31:0] bit_count,
  output logic [31:0] sd_lba,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_din,
  output logic        dirty,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [31:0] MAX_BYTES = 32'(MAX_BLOCKS * WOZ_BLK_BYTES - WOZ_META_BYTES);
  wtw_state_t state_q, state_d;
  logic [WOZ_BLK_SHIFT-1:0] rel_q, rel_d, last_q, last_d;
  logic [31:0] lba_q, lba_d, bit_count_q, bit_count_d, byte_count_q, byte_count_d, byte_count;
  logic dirty_q, dirty_d, done_q, done_d, err_q, err_d, ack_q, ack_d;
  logic meta_sel_q, meta_sel_d, zero_q, zero_d;
  logic [7:0] meta_byte_q, meta_byte_d, sd_buff_din_q, sd_buff_din_d, ram_rdata;
  logic [13:0] rd_idx;
  logic wr_ok, reject, ack_fall;
  assign byte_count = (bit_count + 32'd7) >> 3;
  assign reject = bit_count == '0 || byte_count > MAX_BYTES;
  assign wr_ok = state_q == IDLE && wr_en && {18'b0, wr_addr} < MAX_BYTES;
  assign ack_fall = ack_q & ~sd_ack;
  // Block n offset o maps to data byte n*512+o-8; block 0 offsets below 8 are metadata instead
  assign rd_idx = {rel_q, sd_buff_addr} - 14'(WOZ_META_BYTES);
  woz_wb_ram u_ram (
    .clk     (clk),
    .we      (wr_ok),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (rd_idx),
    .rdata_q (ram_rdata)
  );
  always_comb begin
    meta_sel_d = rel_q == '0 && sd_buff_addr < 9'(WOZ_META_BYTES);
    meta_byte_d = 8'({byte_count_q, bit_count_q} >> {sd_buff_addr[2:0], 3'b000});
    zero_d = {18'b0, rd_idx} >= byte_count_q;
    sd_buff_din_d = meta_sel_q ? meta_byte_q : zero_q ? 8'h00 : ram_rdata;
    ack_d = sd_ack;
  end
  always_comb begin
    state_d = state_q;
    rel_d = rel_q;
    last_d = last_q;
    lba_d = lba_q;
    bit_count_d = bit_count_q;
    byte_count_d = byte_count_q;
    dirty_d = dirty_q | wr_ok;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (flush) begin
        if (reject) err_d = 1'b1;
        else begin
          bit_count_d = bit_count;
          byte_count_d = byte_count;
          last_d = WOZ_BLK_SHIFT'(((byte_count[14:0] + 15'(WOZ_META_BYTES + WOZ_BLK_BYTES - 1))
                                   >> $clog2(WOZ_BLK_BYTES)) - 15'd1);
          lba_d = woz_lba(side, track);
          rel_d = '0;
          state_d = REQ;
        end
      end
      REQ: if (sd_ack) state_d = XFER;
      XFER: if (ack_fall) begin
        if (rel_q == last_q) begin
          state_d = IDLE;
          dirty_d = 1'b0;
          done_d = 1'b1;
        end else begin
          rel_d = rel_q + 1'b1;
          lba_d = lba_q + 32'd1;
          state_d = NEXT;
        end
      end
      NEXT: state_d = REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rel_q <= '0;
      last_q <= '0;
      lba_q <= '0;
      bit_count_q <= '0;
      byte_count_q <= '0;
      dirty_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
      meta_sel_q <= 1'b0;
      meta_byte_q <= '0;
      zero_q <= 1'b0;
      sd_buff_din_q <= '0;
    end else begin
      state_q <= state_d;
      rel_q <= rel_d;
      last_q <= last_d;
      lba_q <= lba_d;
      bit_count_q <= bit_count_d;
      byte_count_q <= byte_count_d;
      dirty_q <= dirty_d;
      done_q <= done_d;
      err_q <= err_d;
      ack_q <= ack_d;
      meta_sel_q <= meta_sel_d;
      meta_byte_q <= meta_byte_d;
      zero_q <= zero_d;
      sd_buff_din_q <= sd_buff_din_d;
    end
  end
  assign sd_lba = lba_q;
  assign sd_wr = state_q == REQ;
  assign busy = state_q != IDLE;
  assign sd_buff_din = sd_buff_din_q;
  assign dirty = dirty_q;
  assign done = done_q;
  assign err = err_q;
endmodule
